// File: rtl/uart_cmd_regfile.sv
// Parses "#<idx><decimal><CR>" from a UART byte stream, writes the value into a register file
// and answers K/E/T over a valid/ready handshake. Define UART_CMD_TIMEOUT_EN for the inter-byte timeout.
`timescale 1ns/1ps
module uart_cmd_regfile #(
    parameter int                NUM_REGS       = 4,
    parameter int                DATA_W         = 32,
    parameter int                MAX_DIGITS     = 10,
    parameter logic [DATA_W-1:0] RESET_VAL      = '0,
    parameter int                TIMEOUT_CYCLES = 2500000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       from_uart_valid,
    input  logic [7:0]                 from_uart_data,
    output logic [NUM_REGS*DATA_W-1:0] reg_data,
    output logic [NUM_REGS-1:0]        reg_wr_stb,
    output logic                       to_uart_valid,
    output logic [7:0]                 to_uart_data,
    input  logic                       to_uart_ready,
    output logic                       busy
);
    localparam int ACC_W = DATA_W + 4;
    localparam int CNT_W = $clog2(MAX_DIGITS + 1);
    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    localparam logic [ACC_W-1:0] DATA_MAX = {4'b0000, {DATA_W{1'b1}}};
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_DIGITS);
    localparam logic [3:0]       NREGS_4  = 4'(NUM_REGS);

    localparam logic [7:0] CH_HASH  = 8'h23;
    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] RESP_K   = 8'h4B;
    localparam logic [7:0] RESP_E   = 8'h45;
    localparam logic [7:0] RESP_T   = 8'h54;

    typedef enum logic [2:0] {IDLE, GET_IDX, GET_DIGITS, COMMIT, RESP} state_t;

    state_t              state_q;
    logic [ACC_W-1:0]    acc_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                ovf_q;
    logic [IDX_W-1:0]    idx_q;
    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [NUM_REGS-1:0] wr_stb_q;
    logic                tx_valid_q;
    logic [7:0]          tx_data_q;
    logic                busy_q;

    logic                byte_v;
    logic                is_digit;
    logic                is_cr;
    logic                idx_ok;
    logic [3:0]          digit;
    logic [ACC_W-1:0]    acc_d;
    logic                acc_big;
    logic                resp_go;
    logic [7:0]          resp_code;
    logic                tmo_fire;

    assign digit    = from_uart_data[3:0];
    assign is_digit = (from_uart_data >= 8'h30) && (from_uart_data <= 8'h39);
    assign is_cr    = (from_uart_data == CH_CR);
    assign byte_v   = from_uart_valid && (from_uart_data != CH_SPACE);
    assign idx_ok   = is_digit && (digit < NREGS_4);

    // acc*10 + digit; acc never holds more than DATA_W bits, so ACC_W cannot wrap.
    assign acc_d   = (acc_q << 3) + (acc_q << 1) + {{(ACC_W-4){1'b0}}, digit};
    assign acc_big = (acc_d > DATA_MAX) || (cnt_q == CNT_MAX);

`ifdef UART_CMD_TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    logic [TMO_W-1:0] tmo_q;
    logic             in_cmd;

    assign in_cmd = (state_q == GET_IDX) || (state_q == GET_DIGITS);

    always_ff @(posedge clk) begin
        if (rst || from_uart_valid || !in_cmd) tmo_q <= '0;
        else                                   tmo_q <= tmo_q + TMO_W'(1);
    end

    assign tmo_fire = in_cmd && !from_uart_valid && (tmo_q == TMO_LAST);
`else
    assign tmo_fire = 1'b0 && (TIMEOUT_CYCLES > 0);
`endif

    always_comb begin
        // NOTE: every output gets a default first so no branch can leave a latch behind.
        resp_go   = 1'b0;
        resp_code = RESP_E;
        case (state_q)
            GET_IDX: begin
                if (byte_v) resp_go = !idx_ok;
                else if (tmo_fire) begin
                    resp_go   = 1'b1;
                    resp_code = RESP_T;
                end
            end
            GET_DIGITS: begin
                if (byte_v) resp_go = !is_digit && !(is_cr && (cnt_q != '0) && !ovf_q);
                else if (tmo_fire) begin
                    resp_go   = 1'b1;
                    resp_code = RESP_T;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses <= so every flop sees the values from before the edge.
        if (rst) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            idx_q      <= '0;
            wr_stb_q   <= '0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= 8'h00;
            busy_q     <= 1'b0;
            // NOTE: the register file is plain flops, so it is reset like any other state.
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RESET_VAL;
        end else begin
            wr_stb_q <= '0;
            if (resp_go) begin
                state_q    <= RESP;
                tx_valid_q <= 1'b1;
                tx_data_q  <= resp_code;
                busy_q     <= 1'b1;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (from_uart_valid && (from_uart_data == CH_HASH)) begin
                            acc_q   <= '0;
                            cnt_q   <= '0;
                            ovf_q   <= 1'b0;
                            state_q <= GET_IDX;
                        end
                    end
                    GET_IDX: begin
                        if (byte_v) begin
                            idx_q   <= digit[IDX_W-1:0];
                            state_q <= GET_DIGITS;
                        end
                    end
                    GET_DIGITS: begin
                        if (byte_v) begin
                            if (is_digit) begin
                                if (!ovf_q) begin
                                    if (acc_big) ovf_q <= 1'b1;
                                    else begin
                                        acc_q <= acc_d;
                                        cnt_q <= cnt_q + CNT_W'(1);
                                    end
                                end
                            end else begin
                                // only a well-formed CR survives the error decode
                                state_q <= COMMIT;
                                busy_q  <= 1'b1;
                            end
                        end
                    end
                    COMMIT: begin
                        for (int i = 0; i < NUM_REGS; i++) begin
                            if (idx_q == IDX_W'(i)) begin
                                regs_q[i]   <= acc_q[DATA_W-1:0];
                                wr_stb_q[i] <= 1'b1;
                            end
                        end
                        tx_valid_q <= 1'b1;
                        tx_data_q  <= RESP_K;
                        state_q    <= RESP;
                    end
                    RESP: begin
                        if (to_uart_ready) begin
                            tx_valid_q <= 1'b0;
                            busy_q     <= 1'b0;
                            state_q    <= IDLE;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
        assign reg_data[g*DATA_W +: DATA_W] = regs_q[g];
    end

    assign reg_wr_stb    = wr_stb_q;
    assign to_uart_valid = tx_valid_q;
    assign to_uart_data  = tx_data_q;
    assign busy          = busy_q;

endmodule
